// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop sync, debounce filter, clean level and
// single-cycle press / release / long-press events. Keys are independent channels.
module key_chan #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic clean_n,
  output logic press,
  output logic rel,
  output logic lng,
  output logic held
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);

  localparam logic [1:0] S_REL = 2'd0;
  localparam logic [1:0] S_PRS = 2'd1;
  localparam logic [1:0] S_LNG = 2'd2;

  logic          s1, s2, st;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [1:0]    state;
  logic          acc;

  // level change accepted this edge: differs from st for DEBOUNCE_CYCLES samples
  assign acc     = (s2 != st) && (dcnt == DMAX);
  assign clean_n = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      st    <= 1'b1;
      dcnt  <= '0;
      hcnt  <= '0;
      state <= S_REL;
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
      held  <= 1'b0;
    end else begin
      s1    <= raw_n;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;

      if (s2 == st)        dcnt <= '0;
      else if (!acc)       dcnt <= dcnt + DW'(1);
      else begin
        st   <= s2;
        dcnt <= '0;
      end

      // release takes priority over a long-press firing on the same edge
      case (state)
        S_REL: if (acc) begin
          press <= 1'b1;
          hcnt  <= '0;
          state <= S_PRS;
        end
        S_PRS: if (acc) begin
          rel   <= 1'b1;
          state <= S_REL;
        end else if (hcnt == HMAX) begin
          lng   <= 1'b1;
          held  <= 1'b1;
          state <= S_LNG;
        end else begin
          hcnt  <= hcnt + HW'(1);
        end
        S_LNG: if (acc) begin
          rel   <= 1'b1;
          held  <= 1'b0;
          state <= S_REL;
        end
        default: state <= S_REL;
      endcase
    end
  end
endmodule

module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_clean_n,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] long_held
);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .raw_n  (key_raw_n[k]),
      .clean_n(key_clean_n[k]),
      .press  (press_pulse[k]),
      .rel    (release_pulse[k]),
      .lng    (long_pulse[k]),
      .held   (long_held[k])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: scenario tasks push expected event pulses into a
// scoreboard; a negedge monitor pops and compares whenever any pulse is seen.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int DEB = 4;
  localparam int LNG = 16;
  localparam int LAT = 2 + DEB;

  logic          clk, reset;
  logic [NK-1:0] key_raw_n, key_clean_n, press_pulse, release_pulse, long_pulse, long_held;

  typedef struct {
    int          cyc;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .clk(clk), .reset(reset), .key_raw_n(key_raw_n), .key_clean_n(key_clean_n),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .long_held(long_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    ev_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      total++; bad++;
      $display("FAIL missing_event cyc=%0d expected at cyc=%0d press=%b rel=%b long=%b",
               cyc, e.cyc, e.pr, e.rl, e.lg);
    end
    if ((press_pulse | release_pulse | long_pulse) != '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d press=%b rel=%b long=%b, expected none",
                 cyc, press_pulse, release_pulse, long_pulse);
      end else begin
        e = q.pop_front();
        if (e.cyc !== cyc || e.pr !== press_pulse || e.rl !== release_pulse || e.lg !== long_pulse) begin
          bad++;
          $display("FAIL event cyc=%0d press=%b rel=%b long=%b, expected cyc=%0d press=%b rel=%b long=%b",
                   cyc, press_pulse, release_pulse, long_pulse, e.cyc, e.pr, e.rl, e.lg);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                      input logic [NK-1:0] lg);
    ev_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg;
    q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1; key_raw_n = '1;
    tick(3);
    total++;
    if (key_clean_n !== 4'hF || long_held !== 4'h0 || press_pulse !== 4'h0 ||
        release_pulse !== 4'h0 || long_pulse !== 4'h0) begin
      bad++;
      $display("FAIL reset_values clean=%b held=%b pr=%b rl=%b lg=%b, expected F/0/0/0/0",
               key_clean_n, long_held, press_pulse, release_pulse, long_pulse);
    end
    reset = 1'b0;
    tick(10);
    total++;
    if (key_clean_n !== 4'hF) begin
      bad++; $display("FAIL reset_exit clean=%b expected 1111", key_clean_n);
    end
  endtask

  task automatic test_clean_press;
    int c;
    c = cyc; key_raw_n[0] = 1'b0;
    push(c + LAT, 4'b0001, 4'b0, 4'b0);
    tick(LAT - 1);
    total++;
    if (key_clean_n !== 4'hF) begin
      bad++; $display("FAIL press_early clean=%b expected 1111", key_clean_n);
    end
    tick(1);
    total++;
    if (key_clean_n !== 4'b1110 || long_held !== 4'h0) begin
      bad++; $display("FAIL press_level clean=%b held=%b expected 1110/0000", key_clean_n, long_held);
    end
    c = cyc; key_raw_n[0] = 1'b1;
    push(c + LAT, 4'b0, 4'b0001, 4'b0);
    tick(LAT + 2);
    total++;
    if (key_clean_n !== 4'hF) begin
      bad++; $display("FAIL press_release clean=%b expected 1111", key_clean_n);
    end
  endtask

  task automatic test_glitch;
    int c;
    key_raw_n[1] = 1'b0;
    tick(3);
    key_raw_n[1] = 1'b1;
    tick(10);
    total++;
    if (key_clean_n !== 4'hF) begin
      bad++; $display("FAIL glitch_reject clean=%b expected 1111", key_clean_n);
    end
    c = cyc; key_raw_n[1] = 1'b0;
    push(c + LAT, 4'b0010, 4'b0, 4'b0);
    tick(5);
    c = cyc; key_raw_n[1] = 1'b1;
    push(c + LAT, 4'b0, 4'b0010, 4'b0);
    tick(LAT);
    total++;
    if (key_clean_n !== 4'hF) begin
      bad++; $display("FAIL glitch_accept_release clean=%b expected 1111", key_clean_n);
    end
    tick(4);
  endtask

  task automatic test_long_press;
    int c;
    c = cyc; key_raw_n[2] = 1'b0;
    push(c + LAT, 4'b0100, 4'b0, 4'b0);
    push(c + LAT + LNG, 4'b0, 4'b0, 4'b0100);
    tick(LAT + LNG - 1);
    total++;
    if (long_held !== 4'h0 || key_clean_n !== 4'b1011) begin
      bad++; $display("FAIL long_before held=%b clean=%b expected 0000/1011", long_held, key_clean_n);
    end
    tick(1);
    total++;
    if (long_held !== 4'b0100) begin
      bad++; $display("FAIL long_held_set held=%b expected 0100", long_held);
    end
    tick(20);
    c = cyc; key_raw_n[2] = 1'b1;
    push(c + LAT, 4'b0, 4'b0100, 4'b0);
    tick(LAT - 1);
    total++;
    if (long_held !== 4'b0100) begin
      bad++; $display("FAIL long_held_keep held=%b expected 0100", long_held);
    end
    tick(1);
    total++;
    if (long_held !== 4'h0 || key_clean_n !== 4'hF) begin
      bad++; $display("FAIL long_release held=%b clean=%b expected 0000/1111", long_held, key_clean_n);
    end
    tick(4);
  endtask

  task automatic test_short_press;
    int c;
    c = cyc; key_raw_n[3] = 1'b0;
    push(c + LAT, 4'b1000, 4'b0, 4'b0);
    tick(LAT + 4);
    c = cyc; key_raw_n[3] = 1'b1;
    push(c + LAT, 4'b0, 4'b1000, 4'b0);
    tick(LAT + LNG + 4);
    total++;
    if (long_held !== 4'h0 || key_clean_n !== 4'hF) begin
      bad++; $display("FAIL short_press held=%b clean=%b expected 0000/1111", long_held, key_clean_n);
    end
  endtask

  task automatic test_simultaneous;
    int c;
    c = cyc; key_raw_n = 4'b0110;
    push(c + LAT, 4'b1001, 4'b0, 4'b0);
    tick(LAT);
    total++;
    if (key_clean_n !== 4'b0110) begin
      bad++; $display("FAIL simul_level clean=%b expected 0110", key_clean_n);
    end
    tick(2);
    c = cyc; key_raw_n = 4'hF;
    push(c + LAT, 4'b0, 4'b1001, 4'b0);
    tick(LAT + 2);
  endtask

  task automatic test_reset_mid_hold;
    int c, r;
    c = cyc; key_raw_n[1] = 1'b0;
    push(c + LAT, 4'b0010, 4'b0, 4'b0);
    tick(LAT + 8);
    reset = 1'b1;
    tick(1);
    total++;
    if (key_clean_n !== 4'hF || long_held !== 4'h0) begin
      bad++; $display("FAIL reset_mid clean=%b held=%b expected 1111/0000", key_clean_n, long_held);
    end
    tick(1);
    reset = 1'b0; r = cyc;
    push(r + LAT, 4'b0010, 4'b0, 4'b0);
    push(r + LAT + LNG, 4'b0, 4'b0, 4'b0010);
    tick(LAT);
    total++;
    if (key_clean_n !== 4'b1101) begin
      bad++; $display("FAIL reset_redetect clean=%b expected 1101", key_clean_n);
    end
    tick(LNG);
    total++;
    if (long_held !== 4'b0010) begin
      bad++; $display("FAIL reset_long held=%b expected 0010", long_held);
    end
    c = cyc; key_raw_n[1] = 1'b1;
    push(c + LAT, 4'b0, 4'b0010, 4'b0);
    tick(LAT + 4);
  endtask

  initial begin
    reset = 1'b1; key_raw_n = '1;
    test_reset;
    test_clean_press;
    test_glitch;
    test_long_press;
    test_short_press;
    test_simultaneous;
    test_reset_mid_hold;
    tick(2);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
